// File: rtl/multirate_mul_acc_pipe.sv
// -----------------------------------------------------------------------------
// multirate_mul_acc_pipe
//   Pipelined signed x unsigned multiply-accumulate for the multirate FIR
//   filterbank. Each in_first..in_last burst of (sample, coefficient) beats is
//   reduced to one dot product. That sum is rounded half-up, shifted right by
//   SHIFT, saturated to DOUT_WIDTH and delivered over a valid/ready stream.
//
// Ports
//   ap_clk, ap_rst_n   clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  input beat handshake (din0, din1, in_first, in_last)
//   din0               signed sample
//   din1               unsigned coefficient (zero-extended)
//   in_first/in_last   burst delimiters (both set = single-product result)
//   out_valid/out_ready output handshake
//   dout               rounded, saturated result
//   out_sat            1 when dout was clipped
// -----------------------------------------------------------------------------
module multirate_mul_acc_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 13,
  parameter int ACC_WIDTH  = 40,
  parameter int DOUT_WIDTH = 16,
  parameter int SHIFT      = 12,
  parameter int NUM_STAGE  = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_sat
);

  localparam int PW   = DIN0_WIDTH + DIN1_WIDTH + 1;
  localparam int LAST = NUM_STAGE - 1;

  localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH+1)'(1) << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] DMAX = (ACC_WIDTH+1)'(2**(DOUT_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] DMIN = (ACC_WIDTH+1)'(-(2**(DOUT_WIDTH-1)));

  // A single global enable: the whole pipe advances only when the output
  // register is free or being emptied this cycle, so nothing is ever dropped.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Coefficient gets a zero MSB so the multiply is signed x unsigned.
  logic signed [PW-1:0] prod_in;
  assign prod_in = $signed(din0) * $signed({1'b0, din1});

  logic signed [PW-1:0] prod_q  [NUM_STAGE];
  logic [NUM_STAGE-1:0] first_q, last_q, vld_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments let every stage read the previous
      // stage's old value, so the loop builds a shift register, not a wire.
      vld_q[0] <= in_valid;
      for (int i = 1; i < NUM_STAGE; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // NOTE: the data/tag registers carry no reset; they are qualified by vld_q,
  // which is reset, so their power-up contents are never observed.
  always_ff @(posedge ap_clk) begin
    if (en) begin
      prod_q[0]  <= prod_in;
      first_q[0] <= in_first;
      last_q[0]  <= in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_q[i]  <= prod_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  // Accumulate and round/saturate in the same cycle as the final product.
  logic signed [ACC_WIDTH-1:0] acc_q, acc_next, prod_ext;
  logic signed [ACC_WIDTH:0]   rnd, r;
  logic [DOUT_WIDTH-1:0]       res_dout;
  logic                        res_sat;

  assign prod_ext = ACC_WIDTH'(prod_q[LAST]);
  assign acc_next = (first_q[LAST] ? '0 : acc_q) + prod_ext;
  // One extra bit so adding the half-LSB cannot wrap near the positive limit.
  assign rnd = (ACC_WIDTH+1)'(acc_next) + HALF;
  assign r   = rnd >>> SHIFT;

  always_comb begin
    // NOTE: defaults first keep every path assigned, so no latch is inferred.
    res_dout = r[DOUT_WIDTH-1:0];
    res_sat  = 1'b0;
    if (r > DMAX) begin
      res_dout = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
      res_sat  = 1'b1;
    end else if (r < DMIN) begin
      res_dout = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
      res_sat  = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q     <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      // Clearing on the last beat means a burst missing in_first still
      // starts from zero.
      if (vld_q[LAST]) acc_q <= last_q[LAST] ? '0 : acc_next;
      out_valid <= vld_q[LAST] && last_q[LAST];
      if (vld_q[LAST] && last_q[LAST]) begin
        dout    <= res_dout;
        out_sat <= res_sat;
      end
    end
  end

endmodule

// File: tb/tb_multirate_mul_acc_pipe.sv
// -----------------------------------------------------------------------------
// tb_multirate_mul_acc_pipe
//   Scoreboard bench: the driver pushes expected results from an arithmetic
//   reference model when a burst's last beat is accepted; an independent
//   monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_multirate_mul_acc_pipe;

  localparam int NUM_STAGE = 2;
  localparam int SHIFT     = 12;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid, in_ready, in_first, in_last;
  logic [15:0] din0;
  logic [12:0] din1;
  logic        out_valid, out_ready, out_sat;
  logic [15:0] dout;

  multirate_mul_acc_pipe #(
    .DIN0_WIDTH(16), .DIN1_WIDTH(13), .ACC_WIDTH(40),
    .DOUT_WIDTH(16), .SHIFT(SHIFT), .NUM_STAGE(NUM_STAGE)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_sat(out_sat)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    longint d;
    bit     sat;
  } exp_t;

  exp_t   exp_q[$];
  longint m_acc;
  int     checks = 0;
  int     errors = 0;
  bit     rand_bp = 0;
  int     stall_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the burst.
  function automatic longint wrap40(input longint x);
    longint y;
    y = x & ((64'sd1 <<< 40) - 1);
    if (y[39]) y = y - (64'sd1 <<< 40);
    return y;
  endfunction

  task automatic model_beat(input int d0, input int d1, input bit f, input bit l);
    longint r;
    exp_t   e;
    m_acc = wrap40((f ? 64'sd0 : m_acc) + longint'(d0) * longint'(d1));
    if (l) begin
      r = (m_acc + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;   // floor division
      e.sat = 1'b0;
      e.d   = r;
      if (r > 32767)       begin e.d = 32767;  e.sat = 1'b1; end
      else if (r < -32768) begin e.d = -32768; e.sat = 1'b1; end
      exp_q.push_back(e);
      m_acc = 0;
    end
  endtask

  // Drive one beat; returns just after the accepting edge.
  task automatic send_beat(input int d0, input int d1, input bit f, input bit l);
    bit done = 0;
    int tries = 0;
    while (!done) begin
      @(negedge ap_clk);
      in_valid = 1'b1;
      din0 = 16'(d0);
      din1 = 13'(d1);
      in_first = f;
      in_last = l;
      #1;
      done = in_ready;
      @(posedge ap_clk);
      if (done) model_beat(d0, d1, f, l);
      #1 in_valid = 1'b0;
      tries++;
      if (!done && tries > 200) begin
        check("send_timeout", 0, 1);
        done = 1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge ap_clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Back-pressure generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge ap_clk);
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      else if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else out_ready = 1'b1;
    end
  end

  // Monitor: compares on handshake, checks hold and in_ready while stalled.
  initial begin
    bit          prev_stall = 0;
    logic [15:0] prev_dout;
    logic        prev_sat;
    exp_t        e;
    forever begin
      @(negedge ap_clk);
      #2;
      if (!ap_rst_n) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_dout", longint'($signed(dout)), longint'($signed(prev_dout)));
        check("hold_sat", out_sat, prev_sat);
      end
      if (out_valid && !out_ready) check("in_ready_stalled", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("dout", longint'($signed(dout)), e.d);
          check("out_sat", out_sat, e.sat);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_dout  = dout;
      prev_sat   = out_sat;
    end
  end

  initial begin
    int k;
    ap_rst_n = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    din0 = '0;
    din1 = '0;
    m_acc = 0;
    repeat (2) @(negedge ap_clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    ap_rst_n = 1'b1;

    // Single product and latency.
    send_beat(-3, 4096, 1, 1);
    k = 1;
    #1;
    while (!out_valid && k < 20) begin
      @(posedge ap_clk);
      #1;
      k++;
    end
    check("latency_edges", k, NUM_STAGE + 1);
    drain();

    // Dot product: 314369 -> 77.
    send_beat(100, 4096, 1, 0);
    send_beat(-50, 2048, 0, 0);
    send_beat(7, 1024, 0, 0);
    send_beat(1, 1, 0, 1);
    // Saturation both ways.
    for (int i = 0; i < 4; i++) send_beat(32767, 8191, i == 0, i == 3);
    for (int i = 0; i < 4; i++) send_beat(-32768, 8191, i == 0, i == 3);
    // Rounding boundaries.
    send_beat(1, 2048, 1, 1);
    send_beat(-1, 2048, 1, 1);
    send_beat(1, 2047, 1, 1);
    // Burst without in_first after a completed burst starts from zero.
    send_beat(5, 4096, 0, 1);
    drain();

    // Back-pressure: 8 results, 5-cycle stall mid-stream.
    for (int i = 0; i < 8; i++) begin
      if (i == 4) stall_cnt = 5;
      send_beat(1000 * (i + 1) - 3000, 4096, 1, 1);
    end
    drain();

    // Reset mid-burst: partial sum discarded.
    send_beat(20000, 8000, 1, 0);
    send_beat(20000, 8000, 0, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    m_acc = 0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_dout", dout, 0);
    check("midrst_out_sat", out_sat, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    send_beat(9, 4096, 0, 1);
    drain();

    // Randomized bursts under random back-pressure.
    rand_bp = 1;
    for (int b = 0; b < 60; b++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        int d0, d1;
        d0 = int'($signed(16'($urandom)));
        d1 = int'($urandom_range(0, 8191));
        if ($urandom_range(0, 7) == 0) d0 = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
        send_beat(d0, d1, (j == 0) && ($urandom_range(0, 4) != 0), j == len - 1);
        if ($urandom_range(0, 3) == 0) @(negedge ap_clk);
      end
    end
    rand_bp = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
